// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: producer/consumer bundle for sync_fifo_param.
interface sync_fifo_param_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
);
    localparam int ADDR_W = $clog2(DEPTH);
    logic              flush;
    logic              we;
    logic [DATA_W-1:0] datain;
    logic              re;
    logic [DATA_W-1:0] dataout;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;
    modport master (
        output flush, we, datain, re,
        input  dataout, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
    modport slave (
        input  flush, we, datain, re,
        output dataout, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with thresholds, FWFT mode, flush and error pulses.
module sync_fifo_param #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input logic              clk,
    input logic              rst_n,
    sync_fifo_param_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W:0]   wptr_q, wptr_d, rptr_q, rptr_d, count;
    logic [DATA_W-1:0] dout_q, dout_d, head;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic              full, empty, wr_en, rd_en;

    // Status is decoded only from registered pointers; the extra MSB separates full from empty.
    assign count = wptr_q - rptr_q;
    assign empty = wptr_q == rptr_q;
    assign full  = (wptr_q[ADDR_W] != rptr_q[ADDR_W]) && (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]);
    assign wr_en = bus.we & ~full & ~bus.flush;
    assign rd_en = bus.re & ~empty & ~bus.flush;
    assign head  = mem_q[rptr_q[ADDR_W-1:0]];

    always_comb begin
        wptr_d = bus.flush ? '0 : wptr_q + (ADDR_W+1)'(wr_en);
        rptr_d = bus.flush ? '0 : rptr_q + (ADDR_W+1)'(rd_en);
        dout_d = bus.flush ? '0 : (FWFT == 0 && rd_en) ? head : dout_q;
        ovf_d  = bus.we & full & ~bus.flush;
        unf_d  = bus.re & empty & ~bus.flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            dout_q <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            dout_q <= dout_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    // Storage is intentionally left unreset; flush and reset only move the pointers.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q[ADDR_W-1:0]] <= bus.datain;
    end

    assign bus.dataout      = (FWFT != 0 && !empty) ? head : dout_q;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.count        = count;
    assign bus.almost_full  = count >= (ADDR_W+1)'(AF_THRESH);
    assign bus.almost_empty = count <= (ADDR_W+1)'(AE_THRESH);
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: randomised queue-model bench for a registered-read and an FWFT FIFO instance.
module tb_sync_fifo_param;
    localparam int DW = 8;
    localparam int D  = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    sync_fifo_param_if #(.DATA_W(DW), .DEPTH(D)) if0 ();
    sync_fifo_param_if #(.DATA_W(DW), .DEPTH(D)) if1 ();

    sync_fifo_param #(.DATA_W(DW), .DEPTH(D), .AF_THRESH(6), .AE_THRESH(2), .FWFT(0))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    sync_fifo_param #(.DATA_W(DW), .DEPTH(D), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    int checks = 0;
    int pass = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] m_dout0 = 8'h00;
    logic m_ovf0 = 1'b0, m_unf0 = 1'b0, m_ovf1 = 1'b0, m_unf1 = 1'b0;

    wire [17:0] obs0 = {if0.full, if0.empty, if0.almost_full, if0.almost_empty,
                        if0.overflow, if0.underflow, if0.count, if0.dataout};
    wire [17:0] obs1 = {if1.full, if1.empty, if1.almost_full, if1.almost_empty,
                        if1.overflow, if1.underflow, if1.count, if1.empty ? 8'h00 : if1.dataout};

    function automatic logic [17:0] exp0();
        int n = q0.size();
        return {n == D, n == 0, n >= 6, n <= 2, m_ovf0, m_unf0, 4'(n), m_dout0};
    endfunction

    // FWFT head is only meaningful while non-empty; masked to zero otherwise.
    function automatic logic [17:0] exp1();
        int n = q1.size();
        logic [7:0] h = 8'h00;
        if (n != 0) h = q1[0];
        return {n == D, n == 0, n >= 6, n <= 2, m_ovf1, m_unf1, 4'(n), h};
    endfunction

    task automatic tick(input bit d1, input logic we, input logic re, input logic fl, input logic [7:0] din);
        int n;
        if (d1) begin
            if1.we = we; if1.re = re; if1.flush = fl; if1.datain = din;
            n = q1.size();
            m_ovf0 = 1'b0; m_unf0 = 1'b0;
            if (fl) begin
                q1.delete(); m_ovf1 = 1'b0; m_unf1 = 1'b0;
            end else begin
                m_ovf1 = we && n == D;
                m_unf1 = re && n == 0;
                if (re && n != 0) void'(q1.pop_front());
                if (we && n != D) q1.push_back(din);
            end
        end else begin
            if0.we = we; if0.re = re; if0.flush = fl; if0.datain = din;
            n = q0.size();
            m_ovf1 = 1'b0; m_unf1 = 1'b0;
            if (fl) begin
                q0.delete(); m_dout0 = 8'h00; m_ovf0 = 1'b0; m_unf0 = 1'b0;
            end else begin
                m_ovf0 = we && n == D;
                m_unf0 = re && n == 0;
                if (re && n != 0) m_dout0 = q0.pop_front();
                if (we && n != D) q0.push_back(din);
            end
        end
        @(posedge clk);
        #1;
        if0.we = 1'b0; if0.re = 1'b0; if0.flush = 1'b0; if0.datain = 8'h00;
        if1.we = 1'b0; if1.re = 1'b0; if1.flush = 1'b0; if1.datain = 8'h00;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        if (obs0 !== exp0()) $display("FAIL reset0 got %h exp %h", obs0, exp0()); else pass++;
        checks++;
        if (obs1 !== exp1()) $display("FAIL reset1 got %h exp %h", obs1, exp1()); else pass++;
        checks++;
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 9; i++) begin
            tick(1'b0, 1'b1, 1'b0, 1'b0, 8'(i));
            if (obs0 !== exp0()) $display("FAIL fill[%0d] got %h exp %h", i, obs0, exp0()); else pass++;
            checks++;
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        if (obs0 !== exp0()) $display("FAIL fill_ovf_drop got %h exp %h", obs0, exp0()); else pass++;
        checks++;
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 9; i++) begin
            tick(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
            if (obs0 !== exp0()) $display("FAIL drain[%0d] got %h exp %h", i, obs0, exp0()); else pass++;
            checks++;
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        if (obs0 !== exp0()) $display("FAIL drain_unf_drop got %h exp %h", obs0, exp0()); else pass++;
        checks++;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 1'b1, 1'b1, 1'b0, 8'(8'h43 + i));
            if (obs0 !== exp0()) $display("FAIL wrap[%0d] got %h exp %h", i, obs0, exp0()); else pass++;
            checks++;
        end
    endtask

    task automatic test_boundaries();
        for (int i = 0; i < 2 * D && q0.size() < D; i++) tick(1'b0, 1'b1, 1'b0, 1'b0, 8'($urandom));
        tick(1'b0, 1'b1, 1'b1, 1'b0, 8'hEE);
        if (obs0 !== exp0()) $display("FAIL both_full got %h exp %h", obs0, exp0()); else pass++;
        checks++;
        for (int i = 0; i < 2 * D && q0.size() > 0; i++) tick(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 8'h77);
        if (obs0 !== exp0()) $display("FAIL both_empty got %h exp %h", obs0, exp0()); else pass++;
        checks++;
        tick(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        if (obs0 !== exp0()) $display("FAIL both_empty_read got %h exp %h", obs0, exp0()); else pass++;
        checks++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            tick(1'b0, 1'($urandom), 1'($urandom), $urandom_range(19) == 0, 8'($urandom));
            if (obs0 !== exp0()) $display("FAIL rand[%0d] got %h exp %h", i, obs0, exp0()); else pass++;
            checks++;
        end
    endtask

    task automatic test_fwft();
        tick(1'b1, 1'b1, 1'b0, 1'b0, 8'hA5);
        if (obs1 !== exp1()) $display("FAIL fwft_first got %h exp %h", obs1, exp1()); else pass++;
        checks++;
        tick(1'b1, 1'b1, 1'b0, 1'b0, 8'h3C);
        tick(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        if (obs1 !== exp1()) $display("FAIL fwft_advance got %h exp %h", obs1, exp1()); else pass++;
        checks++;
        tick(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        if (obs1 !== exp1()) $display("FAIL fwft_empty got %h exp %h", obs1, exp1()); else pass++;
        checks++;
        for (int i = 0; i < 200; i++) begin
            tick(1'b1, 1'($urandom), 1'($urandom), $urandom_range(19) == 0, 8'($urandom));
            if (obs1 !== exp1()) $display("FAIL fwft_rand[%0d] got %h exp %h", i, obs1, exp1()); else pass++;
            checks++;
        end
    endtask

    task automatic test_flush();
        tick(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 1'b0, 1'b0, 8'(8'h50 + i));
        tick(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        tick(1'b0, 1'b1, 1'b1, 1'b1, 8'h99);
        if (obs0 !== exp0()) $display("FAIL flush got %h exp %h", obs0, exp0()); else pass++;
        checks++;
        tick(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        if (obs0 !== exp0()) $display("FAIL flush_after got %h exp %h", obs0, exp0()); else pass++;
        checks++;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b0, 1'b0, 8'(8'h60 + i));
        tick(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 1'b0, 8'(8'h70 + i));
        #3 rst_n = 1'b0;
        q0.delete(); q1.delete();
        m_dout0 = 8'h00; m_ovf0 = 1'b0; m_unf0 = 1'b0; m_ovf1 = 1'b0; m_unf1 = 1'b0;
        #1;
        if (obs0 !== exp0()) $display("FAIL async_rst0 got %h exp %h", obs0, exp0()); else pass++;
        checks++;
        if (obs1 !== exp1()) $display("FAIL async_rst1 got %h exp %h", obs1, exp1()); else pass++;
        checks++;
        #2 rst_n = 1'b1;
        tick(1'b0, 1'b1, 1'b0, 1'b0, 8'h5A);
        if (obs0 !== exp0()) $display("FAIL post_rst_write got %h exp %h", obs0, exp0()); else pass++;
        checks++;
    endtask

    initial begin
        if0.we = 1'b0; if0.re = 1'b0; if0.flush = 1'b0; if0.datain = 8'h00;
        if1.we = 1'b0; if1.re = 1'b0; if1.flush = 1'b0; if1.datain = 8'h00;
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_boundaries();
        test_random();
        test_fwft();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", pass, checks);
        $finish;
    end
endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised synchronous FIFO, the successor to the fixed 32-bit × 1024 single-clock FIFO. It adds:
- configurable data width and depth;
- an occupancy count with almost-full and almost-empty thresholds;
- a selectable first-word-fall-through (FWFT) read mode;
- a synchronous flush;
- overflow and underflow error pulses.

It sits between a producer and a consumer in the same clock domain, as a drop-in rate-decoupling buffer.

## Interface
Parameters:
- DATA_W, 32, data word width in bits (≥1).
- DEPTH, 16, number of entries; power of two, ≥2. ADDR_W = log2(DEPTH).
- AF_THRESH, DEPTH-2, almost_full asserts when count ≥ AF_THRESH (1..DEPTH).
- AE_THRESH, 2, almost_empty asserts when count ≤ AE_THRESH (0..DEPTH-1).
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through.

Ports:
- clk  in  1  the single clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- flush  in  1  synchronous clear of FIFO contents; has priority over we and re.
- we  in  1  write request.
- datain  in  DATA_W  write data, sampled when a write is accepted.
- re  in  1  read request.
- dataout  out  DATA_W  read data.
- full  out  1  FIFO holds DEPTH entries.
- empty  out  1  no readable word (see Operation for the FWFT meaning).
- almost_full  out  1  count ≥ AF_THRESH.
- almost_empty  out  1  count ≤ AE_THRESH.
- count  out  ADDR_W+1  number of stored entries, 0..DEPTH.
- overflow  out  1  one-cycle pulse: write requested while full.
- underflow  out  1  one-cycle pulse: read requested while empty.

## Operation
- Storage: DEPTH × DATA_W register array. The array is not reset.
- Pointers: wptr and rptr are ADDR_W+1 bits. The low ADDR_W bits address the array; the MSB is a wrap bit.
  - empty when wptr == rptr.
  - full when the MSBs differ and the low bits are equal.
  - Pointers wrap modulo 2·DEPTH.
- A write is accepted when we & !full & !flush. The array location wptr[ADDR_W-1:0] is written with datain, and wptr increments.
- A read is accepted when re & !empty & !flush, and rptr increments.
- full and empty used for acceptance are the values before the clock edge.
  - Simultaneous we & re when full: the read is accepted and the write is rejected.
  - Simultaneous we & re when empty: the write is accepted and the read is rejected. There is no bypass.
  - Simultaneous we & re otherwise: both are accepted and count is unchanged.
- count = wptr − rptr, modulo 2^(ADDR_W+1). It is held as a register or derived combinationally; both meet the timing below.
- Registered mode (FWFT=0):
  - On an accepted read, dataout loads mem[rptr] at that edge.
  - Otherwise dataout holds its value.
- FWFT mode (FWFT=1):
  - dataout = mem[rptr] combinationally whenever empty=0. It is don't-care while empty=1.
  - An accepted read advances to the next word.
- overflow = we & full & !flush, registered so it pulses in the cycle after the request.
- underflow = re & empty & !flush, registered the same way.
- flush:
  - wptr, rptr and count go to 0, and dataout goes to 0.
  - Array contents are left stale.
  - No overflow or underflow pulse is generated.
- Reset (rst_n=0), immediate and independent of clk:
  - wptr = rptr = 0, count = 0, dataout = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0, overflow = underflow = 0.
  - Reset mid-operation discards all contents.
  - Deassertion is synchronised externally. The first edge after deassertion may accept a write.

## Timing
- Write-to-visible latency:
  - A word written at edge N makes empty fall after edge N.
  - FWFT=1: dataout is valid in the cycle after edge N.
  - FWFT=0: the word appears on dataout after the read edge.
- Registered read latency is one cycle: re accepted at edge N → dataout valid after edge N.
- full, empty, almost_full, almost_empty and count are decoded only from registered pointers. They settle after the edge that changed the pointers, with no combinational path from we or re.
- overflow and underflow are high for exactly one cycle per offending request cycle.
- Throughput: one write and one read per cycle sustained.

## Test plan
- Reset and fill: DATA_W=8, DEPTH=8, FWFT=0. Write 0x01..0x08 on consecutive cycles, we held on a 9th cycle.
  - Required: count 1..8, almost_full high at count 6, full high after the 8th write.
  - The 9th write is rejected with an overflow pulse one cycle later, and count stays 8.
- Drain in order: from the full state, re held for 9 cycles.
  - Required: dataout shows 0x01..0x08 one cycle after each accepted read.
  - almost_empty goes high at count 2 and empty goes high after the 8th read.
  - The 9th read produces an underflow pulse, and dataout holds 0x08.
- Wrap-around: 20 cycles of simultaneous we/re at a steady count of 3, with an incrementing data pattern.
  - Required: count constant at 3, output sequence equals input delayed by 3 reads, and no flags toggle.
- Simultaneous at boundaries:
  - we & re while full: count goes 8 → 7 and the write data is lost.
  - we & re while empty: count goes 0 → 1, the read is rejected with an underflow pulse, and there is no bypass.
- FWFT=1: write 0xA5 into an empty FIFO.
  - Required: empty falls and dataout = 0xA5 in the next cycle with no re.
  - A re then advances dataout to the next word or sets empty.
- Flush and async reset:
  - flush with count 5 plus we & re: count becomes 0, dataout becomes 0, and there are no error pulses.
  - rst_n pulsed low mid-cycle with count 4: all outputs take their reset values before the next clk edge.
